// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: two-input, packet-granular round-robin arbiter that
// merges two AXI-Stream requesters onto the single AES input stream. The
// grant is held for a whole packet, so packets never interleave, and the
// output passes through one full-throughput register stage.
module axis_packet_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_BEATS          = 1024,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                            m00_axis_aclk,
  input  logic                            m00_axis_aresetn,
  input  logic                            s00_axis_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  output logic                            s00_axis_tready,
  input  logic                            s01_axis_tvalid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                            s01_axis_tlast,
  output logic                            s01_axis_tready,
  output logic                            m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  input  logic                            m00_axis_tready,
  output logic [1:0]                      grant,
  output logic                            err_overlong
);

  localparam int STRB_WIDTH = C_AXIS_TDATA_WIDTH / 8;
  // Counter value held while the beat numbered MAX_BEATS is being presented.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              grant_next;
  logic                    last_grant;       // 1 means requester 1 owned the previous packet
  logic                    last_grant_next;
  logic [CNT_WIDTH-1:0]    beat_cnt;
  logic [CNT_WIDTH-1:0]    beat_cnt_next;

  logic                    in_valid;
  logic                    in_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] in_data;
  logic [STRB_WIDTH-1:0]   in_strb;
  logic                    out_free;
  logic                    accept;
  logic                    load_last;
  logic                    set_err;
  logic                    pick;

  // Route the currently granted requester onto the internal input bus.
  always_comb begin
    in_valid = grant[1] ? s01_axis_tvalid : (grant[0] & s00_axis_tvalid);
    in_last  = grant[1] ? s01_axis_tlast  : s00_axis_tlast;
    in_data  = grant[1] ? s01_axis_tdata  : s00_axis_tdata;
    in_strb  = grant[1] ? s01_axis_tstrb  : s00_axis_tstrb;
  end

  // Next-state logic: round-robin pick in IDLE, beat acceptance and packet
  // end / truncation detection in BUSY.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    beat_cnt_next   = beat_cnt;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    accept          = 1'b0;
    load_last       = 1'b0;
    set_err         = 1'b0;
    out_free        = !m00_axis_tvalid || m00_axis_tready;
    pick            = (s00_axis_tvalid && s01_axis_tvalid) ? !last_grant : s01_axis_tvalid;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid || s01_axis_tvalid) begin
          grant_next      = pick ? 2'b10 : 2'b01;
          last_grant_next = pick;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        s00_axis_tready = grant[0] & out_free;
        s01_axis_tready = grant[1] & out_free;
        accept          = in_valid && out_free;
        if (accept) begin
          load_last = in_last || (beat_cnt == LAST_CNT);
          set_err   = !in_last && (beat_cnt == LAST_CNT);
          if (load_last) begin
            state_next    = IDLE;
            grant_next    = 2'b00;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // Arbitration state: FSM, owner, round-robin history and beat counter.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      beat_cnt   <= beat_cnt_next;
    end
  end

  // Output register: loads on every accepted beat, empties on a handshake.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= in_data;
      m00_axis_tstrb  <= in_strb;
      m00_axis_tlast  <= load_last;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

  // Sticky overlong flag, cleared only by reset.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      err_overlong <= 1'b0;
    end else if (set_err) begin
      err_overlong <= 1'b1;
    end
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
Two-input, packet-granular round-robin arbiter that shares the single AES input AXI-Stream among two requester streams, for example a key/command stream and a bulk-data stream.
- A grant is held from the first accepted beat to the accepted beat carrying tlast, so packets never interleave.
- The output passes through one register stage that sustains full throughput.
- The block sits between the stream sources and the AES core's slave AXI-Stream port.

Parameters:
- C_AXIS_TDATA_WIDTH, 32: data width of all three streams.
- MAX_BEATS, 1024: longest legal packet in beats; a longer packet is truncated and flagged.
- CNT_WIDTH, 16: width of the beat counter; must satisfy 2^CNT_WIDTH > MAX_BEATS.

Ports:
- m00_axis_aclk  input  1  single clock for all interfaces.
- m00_axis_aresetn  input  1  asynchronous, active-low reset.
- s00_axis_tvalid  input  1  requester 0 valid.
- s00_axis_tdata  input  C_AXIS_TDATA_WIDTH  requester 0 data.
- s00_axis_tstrb  input  C_AXIS_TDATA_WIDTH/8  requester 0 strobes.
- s00_axis_tlast  input  1  requester 0 end of packet.
- s00_axis_tready  output  1  requester 0 ready.
- s01_axis_tvalid / tdata / tstrb / tlast / tready: same as s00, for requester 1.
- m00_axis_tvalid  output  1  arbitrated output valid.
- m00_axis_tdata  output  C_AXIS_TDATA_WIDTH  output data.
- m00_axis_tstrb  output  C_AXIS_TDATA_WIDTH/8  output strobes.
- m00_axis_tlast  output  1  output end of packet.
- m00_axis_tready  input  1  downstream ready.
- grant  output  2  one-hot owner of the current packet; 00 when idle.
- err_overlong  output  1  sticky; set when a packet is truncated at MAX_BEATS.

Behaviour:
- Reset: asynchronous assertion, synchronous release.
  - All outputs go to 0; the FSM returns to IDLE.
  - last_grant = 1, so requester 0 wins the first arbitration.
  - The beat counter is cleared.
  - A reset mid-packet drops the packet and the held output beat.
- FSM states:
  - IDLE: grant = 00 and both tready = 0. If any s*_tvalid is high, the winner is chosen round-robin: the requester other than last_grant has priority; if only one is valid, it wins. The winner is latched into grant and last_grant, and the FSM moves to BUSY. Arbitration costs exactly one cycle: no beat is accepted in the IDLE cycle.
  - BUSY: only the granted s*_axis_tready may be high, equal to (!m00_axis_tvalid || m00_axis_tready). The ungranted tready is held at 0.
- Output register:
  - An accepted input beat loads tdata, tstrb and tlast into the output register and sets m00_axis_tvalid on the next edge.
  - m00_axis_tvalid clears on an output handshake unless a new beat loads in the same cycle; a simultaneous load and unload keeps tvalid at 1.
  - Latency is one cycle from input handshake to m00_axis_tvalid. Back-to-back beats flow at one beat per cycle.
  - While m00_axis_tvalid = 1 and m00_axis_tready = 0, the output register and the granted tready are held stable (AXI rule).
- Packet end:
  - When an input beat with tlast = 1 is accepted, the FSM returns to IDLE on the same edge and grant clears.
  - The output register still drains that beat independently of the FSM. The next arbitration can happen while it drains.
  - Minimum gap between packets is one idle input cycle.
- Beat counter:
  - Increments on each accepted input beat and clears on packet end.
  - If the accepted beat is number MAX_BEATS and its tlast = 0, the block forces the registered tlast to 1, sets err_overlong, and returns to IDLE.
  - The remaining beats of the source packet are then arbitrated as a new packet.
- err_overlong: cleared only by reset.
- tvalid handling: an s*_tvalid that drops before a grant is taken simply loses arbitration; requesters are trusted to keep tvalid asserted per AXI.
- Width rules: tstrb passes through unmodified; data is not transformed.

Test Plan:
1. Reset, then s00 sends a 4-beat packet (0xA0..0xA3) with m00_axis_tready = 1 → grant = 01 one cycle after tvalid; output beats A0..A3 appear on consecutive cycles, tlast on A3; grant = 00 afterwards.
2. Both requesters present 3-beat packets simultaneously from reset → s00 packet first, then s01, then s00 again if re-requested. Packets never interleave and grant toggles 01 → 10 → 01.
3. s01 streaming with m00_axis_tready toggling 1,0,0,1 → no beat lost or duplicated; tdata stable during stalls; s01_axis_tready low exactly when the register is full and the output is stalled.
4. MAX_BEATS = 4, s00 sends 6 beats with tlast only on beat 6 → output beat 4 carries tlast = 1 and err_overlong = 1; beats 5–6 come out as a separate 2-beat packet after re-arbitration.
5. Reset asserted mid-packet (beat 2 of 5) → all outputs 0 immediately (asynchronous); after release, a fresh packet from s00 is accepted normally.
6. s00 and s01 each send 1-beat packets continuously → the output alternates s00, s01 with one idle input cycle per packet, and every beat has tlast = 1.
